// File: rtl/random_delay_gen_if.sv
// Control/status bundle between the game-control FSM and the delay generator.
interface random_delay_gen_if #(
  parameter int CNT_W  = 29,
  parameter int LFSR_W = 16
);
  logic              start;
  logic              abort;
  logic              mode;
  logic [CNT_W-1:0]  fixed_delay;
  logic              seed_load;
  logic [LFSR_W-1:0] seed_val;
  logic              busy;
  logic              done;
  logic              expired;
  logic [CNT_W-1:0]  delay_value;
  logic [CNT_W-1:0]  count;

  // Controller side: issues requests, observes status.
  modport master (
    output start, abort, mode, fixed_delay, seed_load, seed_val,
    input  busy, done, expired, delay_value, count
  );

  // Delay generator side.
  modport slave (
    input  start, abort, mode, fixed_delay, seed_load, seed_val,
    output busy, done, expired, delay_value, count
  );
endinterface

// File: rtl/random_delay_gen.sv
// Pseudo-random / fixed delay generator: after an accepted start it counts
// delay_value cycles, then raises done and pulses expired for one cycle.
module random_delay_gen #(
  parameter int          CNT_W     = 29,
  parameter int          LFSR_W    = 16,
  parameter int          RAND_BITS = 16,
  parameter int unsigned MIN_DELAY = 25_000_000,
  parameter int unsigned STEP      = 100_000,
  parameter logic [31:0] SEED      = 32'h0000_ACE1
) (
  input logic                clk,
  input logic                reset,
  random_delay_gen_if.slave  bus
);

  // Wide enough that MIN_DELAY + rand*STEP can never wrap before saturation.
  localparam int W = CNT_W + LFSR_W + 32;
  localparam logic [W-1:0]      CAP       = (W'(1) << CNT_W) - W'(1);
  localparam logic [LFSR_W-1:0] SEED_T    = SEED[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SEED_INIT = (SEED_T == '0) ? LFSR_W'(1) : SEED_T;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr;
  logic              fb;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  dv_q, dv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              expired_q, expired_d;
  logic              arm;

  logic [RAND_BITS-1:0] rand_v;
  logic [W-1:0]         wide;
  logic [CNT_W-1:0]     tgt_sat, tgt_raw, tgt;

  // Feedback taps per supported width; anything else stops elaboration.
  generate
    if (RAND_BITS < 1 || RAND_BITS > LFSR_W) begin : g_bad_rand
      $error("random_delay_gen: RAND_BITS must be in 1..LFSR_W");
    end
    if (LFSR_W == 8) begin : g_l8
      assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    end else if (LFSR_W == 16) begin : g_l16
      assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    end else if (LFSR_W == 24) begin : g_l24
      assign fb = lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16];
    end else if (LFSR_W == 32) begin : g_l32
      assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    end else begin : g_bad_lfsr
      $error("random_delay_gen: LFSR_W must be 8, 16, 24 or 32");
      assign fb = 1'b0;
    end
  endgenerate

  // LFSR free-runs in every state; a seed load overrides the shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              lfsr <= SEED_INIT;
    else if (bus.seed_load) lfsr <= (bus.seed_val == '0) ? LFSR_W'(1) : bus.seed_val;
    else                    lfsr <= {lfsr[LFSR_W-2:0], fb};
  end

  // Target from the pre-shift LFSR (random) or fixed_delay, saturated and clamped to >= 1.
  always_comb begin
    rand_v  = lfsr[RAND_BITS-1:0];
    wide    = W'(MIN_DELAY) + W'(rand_v) * W'(STEP);
    tgt_sat = (wide > CAP) ? CAP[CNT_W-1:0] : wide[CNT_W-1:0];
    tgt_raw = bus.mode ? bus.fixed_delay : tgt_sat;
    tgt     = (tgt_raw == '0) ? CNT_W'(1) : tgt_raw;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      dv_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  // Next-state logic; abort always beats start and expiry.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    dv_d      = dv_q;
    busy_d    = busy_q;
    done_d    = done_q;
    expired_d = 1'b0;
    arm       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) arm = 1'b1;
      end
      COUNT: begin
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          count_d = '0;
        end else if (count_q == dv_q - CNT_W'(1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          expired_d = 1'b1;
          busy_d    = 1'b0;
          count_d   = dv_q;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else if (bus.start) begin
          arm = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (arm) begin
      state_d = COUNT;
      count_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      dv_d    = tgt;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.expired     = expired_q;
  assign bus.delay_value = dv_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_random_delay_gen.sv
// Directed bench: small 8-bit instance for timing/random checks, a second
// instance for saturation of the random target.
module tb_random_delay_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   npass = 0;
  int   ntot  = 0;
  logic seen_done;

  always #5 clk = ~clk;

  random_delay_gen_if #(.CNT_W(8), .LFSR_W(8)) bus_a ();
  random_delay_gen_if #(.CNT_W(8), .LFSR_W(8)) bus_b ();

  random_delay_gen #(.CNT_W(8), .LFSR_W(8), .RAND_BITS(3), .MIN_DELAY(4), .STEP(1),
                     .SEED(32'h0000_ACE1))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));

  random_delay_gen #(.CNT_W(8), .LFSR_W(8), .RAND_BITS(3), .MIN_DELAY(250), .STEP(4),
                     .SEED(32'h0000_ACE1))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.start = 0; bus_a.abort = 0; bus_a.mode = 0; bus_a.fixed_delay = 0;
    bus_a.seed_load = 0; bus_a.seed_val = 0;
    bus_b.start = 0; bus_b.abort = 0; bus_b.mode = 0; bus_b.fixed_delay = 0;
    bus_b.seed_load = 0; bus_b.seed_val = 0;

    // reset state
    #12;
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_exp", bus_a.expired, 0);
    chk("rst_dv", bus_a.delay_value, 0);
    chk("rst_cnt", bus_a.count, 0);
    chk("rst_lfsr", dut_a.lfsr, 8'hE1);
    reset = 0;

    // saturation: 250 + 7*4 = 278 -> 255
    bus_b.seed_load = 1; bus_b.seed_val = 8'h07;
    tick();
    chk("sat_lfsr", dut_b.lfsr, 8'h07);
    bus_b.seed_load = 0; bus_b.start = 1;
    tick();
    chk("sat_dv", bus_b.delay_value, 255);
    bus_b.start = 0;

    // fixed delay 5
    bus_a.mode = 1; bus_a.fixed_delay = 5; bus_a.start = 1;
    tick();
    chk("fix_busy0", bus_a.busy, 1);
    chk("fix_dv", bus_a.delay_value, 5);
    bus_a.start = 0;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("fix_busy", bus_a.busy, 1);
      chk("fix_nodone", bus_a.done, 0);
    end
    tick();
    chk("fix_done", bus_a.done, 1);
    chk("fix_exp", bus_a.expired, 1);
    chk("fix_busy_lo", bus_a.busy, 0);
    chk("fix_cnt", bus_a.count, 5);
    tick();
    chk("fix_exp_lo", bus_a.expired, 0);
    chk("fix_done_hold", bus_a.done, 1);

    // random target from zero seed; start from DONE re-arms
    bus_a.mode = 0; bus_a.seed_load = 1; bus_a.seed_val = 0;
    tick();
    chk("rnd_seed", dut_a.lfsr, 8'h01);
    bus_a.seed_load = 0; bus_a.start = 1;
    tick();
    chk("rnd_dv", bus_a.delay_value, 5);
    chk("rnd_lfsr1", dut_a.lfsr, 8'h02);
    chk("rearm_done_clr", bus_a.done, 0);
    chk("rearm_busy", bus_a.busy, 1);
    bus_a.start = 0;
    tick();
    chk("rnd_lfsr2", dut_a.lfsr, 8'h04);
    repeat (3) tick();
    chk("rnd_cnt4", bus_a.count, 4);
    chk("rnd_nodone", bus_a.done, 0);
    tick();
    chk("rnd_done", bus_a.done, 1);

    // fixed_delay 0 clamps to 1
    bus_a.mode = 1; bus_a.fixed_delay = 0; bus_a.start = 1;
    tick();
    chk("clamp_dv", bus_a.delay_value, 1);
    chk("clamp_nodone", bus_a.done, 0);
    bus_a.start = 0;
    tick();
    chk("clamp_done", bus_a.done, 1);
    chk("clamp_exp", bus_a.expired, 1);

    // abort mid-count
    bus_a.fixed_delay = 10; bus_a.start = 1;
    tick();
    bus_a.start = 0;
    repeat (3) tick();
    chk("abort_cnt3", bus_a.count, 3);
    bus_a.abort = 1;
    tick();
    chk("abort_busy", bus_a.busy, 0);
    chk("abort_cnt", bus_a.count, 0);
    bus_a.abort = 0;
    seen_done = 0;
    repeat (12) begin
      tick();
      seen_done = seen_done | bus_a.done;
    end
    chk("abort_never_done", seen_done, 0);

    // abort + start together in IDLE
    bus_a.abort = 1; bus_a.start = 1;
    tick();
    chk("abort_start_busy", bus_a.busy, 0);
    bus_a.abort = 0; bus_a.start = 0;

    // abort on the expiry edge
    bus_a.fixed_delay = 3; bus_a.start = 1;
    tick();
    bus_a.start = 0;
    repeat (2) tick();
    bus_a.abort = 1;
    tick();
    chk("abort_exp_done", bus_a.done, 0);
    chk("abort_exp_exp", bus_a.expired, 0);
    chk("abort_exp_busy", bus_a.busy, 0);
    bus_a.abort = 0;

    // start held through the count does not disturb timing
    bus_a.fixed_delay = 4; bus_a.start = 1;
    tick();
    repeat (3) tick();
    chk("held_nodone", bus_a.done, 0);
    chk("held_cnt3", bus_a.count, 3);
    tick();
    chk("held_done", bus_a.done, 1);
    chk("held_exp", bus_a.expired, 1);
    chk("held_cnt", bus_a.count, 4);
    tick();
    chk("held_rearm_done", bus_a.done, 0);
    chk("held_rearm_busy", bus_a.busy, 1);
    chk("held_rearm_cnt", bus_a.count, 0);
    bus_a.start = 0;

    // async reset mid-count
    repeat (3) tick();
    chk("rst_mid_cnt3", bus_a.count, 3);
    #2 reset = 1;
    #1;
    chk("arst_busy", bus_a.busy, 0);
    chk("arst_cnt", bus_a.count, 0);
    chk("arst_dv", bus_a.delay_value, 0);
    chk("arst_done", bus_a.done, 0);
    chk("arst_lfsr", dut_a.lfsr, 8'hE1);
    #1 reset = 0;
    bus_a.fixed_delay = 2; bus_a.start = 1;
    tick();
    chk("post_rst_dv", bus_a.delay_value, 2);
    chk("post_rst_busy", bus_a.busy, 1);
    bus_a.start = 0;
    tick();
    chk("post_rst_nodone", bus_a.done, 0);
    tick();
    chk("post_rst_done", bus_a.done, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/random_delay_gen.md
Name: random_delay_gen

Overview:
Parametrised pseudo-random delay generator. It waits a programmable or LFSR-derived number of clock cycles after a start request, then raises done. It generalises the original fixed-width random delay with configurable widths and delay range, a fixed/random mode, seed loading, abort, a single-cycle expiry pulse, and readback of the chosen delay. It sits between the game-control FSM and the reaction-timer stage.

Parameters:
CNT_W, 29, width of the delay counter and of target/delay_value.
LFSR_W, 16, LFSR width. Legal values are 8, 16, 24 and 32; any other value is an elaboration error.
RAND_BITS, 16, number of LFSR LSBs used as the random multiplier. Must satisfy 1 ≤ RAND_BITS ≤ LFSR_W.
MIN_DELAY, 25_000_000, base delay in cycles in random mode.
STEP, 100_000, cycles added per unit of the random value.
SEED, 16'hACE1, LFSR reset value, zero-extended or truncated to LFSR_W. A value of 0 is replaced by 1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  arm request, sampled every edge
abort  in  1  cancel the count or clear done; returns to IDLE
mode  in  1  0 = random delay, 1 = fixed delay
fixed_delay  in  CNT_W  delay used when mode=1
seed_load  in  1  load seed_val into the LFSR
seed_val  in  LFSR_W  seed value; 0 is replaced by 1
busy  out  1  high while counting
done  out  1  high from expiry until the next accepted start or abort
expired  out  1  one-cycle pulse on the expiry edge
delay_value  out  CNT_W  target latched on the last accepted start
count  out  CNT_W  elapsed cycles in the current count

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, expired=0, delay_value=0, count=0, lfsr=SEED (1 if SEED=0).
- LFSR: Fibonacci structure, shift left, feedback into bit 0. It advances every cycle in every state.
- LFSR feedback taps by width:
  - 8: bits 7^5^4^3
  - 16: bits 15^13^12^10
  - 24: bits 23^22^21^16
  - 32: bits 31^21^1^0
- seed_load has priority over shifting: lfsr <= (seed_val==0 ? 1 : seed_val).
- Target computation happens on an accepted start, using the current (pre-shift) LFSR value:
  - mode=0: tgt = MIN_DELAY + lfsr[RAND_BITS-1:0]*STEP. Compute at ≥ CNT_W+LFSR_W+32 bits and saturate to 2^CNT_W-1.
  - mode=1: tgt = fixed_delay.
  - tgt=0 is clamped to 1.
  - The result is latched into delay_value.
- State IDLE:
  - start=1 and abort=0 → COUNT; count<=0; busy<=1.
- State COUNT:
  - abort=1 → IDLE; busy<=0; count<=0. No done and no expired pulse.
  - Otherwise, if count == delay_value-1 → DONE; done<=1; expired<=1; busy<=0; count<=delay_value.
  - Otherwise count<=count+1.
  - start is ignored in this state.
- State DONE:
  - done is held high.
  - abort=1 → IDLE; done<=0.
  - Otherwise start=1 → re-arm exactly as from IDLE; done<=0.
- Timing: for a start accepted at edge E0, done and expired rise at edge E0+delay_value.
- expired is low on every edge except the expiry edge.
- Simultaneous abort and start: abort wins.
- Simultaneous abort and expiry edge: abort wins; done stays 0.
- Reset mid-count: all state and outputs return to reset values asynchronously.

Test Plan:
- Fixed delay: mode=1, fixed_delay=5, start for 1 cycle at edge 0 → busy=1 on edges 0–4; done and expired rise at edge 5; expired low at edge 6; done stays 1; delay_value=5.
- Random target from seed (CNT_W=8, LFSR_W=8, RAND_BITS=3, MIN_DELAY=4, STEP=1): seed_load with seed_val=0 at edge 0 → lfsr=0x01. Start at edge 1 → delay_value=5, done at edge 6. lfsr=0x02 at edge 1 and 0x04 at edge 2.
- Saturation and clamp (CNT_W=8, MIN_DELAY=250, STEP=4, RAND_BITS=3, lfsr[2:0]=7): start → delay_value=255.
  - mode=1 with fixed_delay=0 → delay_value=1; done one edge after start.
- Abort: fixed_delay=10; abort at edge 4 after start → IDLE, count=0, done never rises.
  - Abort coincident with the expiry edge → done=0 and expired=0.
- Re-arm from DONE: start while done=1 → done clears on that edge and a new count begins. start held during COUNT has no effect on timing.
- Async reset mid-count at count=3 → all outputs 0 immediately; lfsr=SEED; next start behaves as from power-up.
